// File: rtl/wb_shadow_dump_if.sv
// Writeback capture and dump stream bundle for wb_shadow_dump.
// The master side is the core/sink harness; the slave side is the shadow dumper.
interface wb_shadow_dump_if;
  logic        wb_e;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic        dump;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        dump_done;
  logic [31:0] commit_cnt;

  modport master (
    output wb_e, wb_a, wb_d, dump, out_ready,
    input  out_valid, out_idx, out_data, out_last, busy, dump_done, commit_cnt
  );

  modport slave (
    input  wb_e, wb_a, wb_d, dump, out_ready,
    output out_valid, out_idx, out_data, out_last, busy, dump_done, commit_cnt
  );
endinterface

// File: rtl/wb_shadow_dump.sv
// Shadow register file fed by the core writeback port; dumps (index, value) beats on a dump rising edge.
// Define WB_SHADOW_DIRTY_ONLY_EN to emit only registers written since the previous dump.
module wb_shadow_dump (
  input  logic             clk,
  input  logic             reset,
  wb_shadow_dump_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] shadow [32];
  logic [31:0] commit_cnt_q;
  logic        dump_q;
  logic [4:0]  idx_q;
  logic [31:0] data_q;
  logic        last_q;

  logic        wr, start, hs, load, load_last;
  logic [4:0]  load_idx;
  logic [31:0] load_data;

  assign wr    = bus.wb_e && (bus.wb_a != 5'd0);
  assign start = bus.dump && !dump_q && (state == IDLE);
  assign hs    = (state == SEND) && bus.out_ready;

`ifdef WB_SHADOW_DIRTY_ONLY_EN
  logic [31:0] dirty, pending, src, src_rest;
  logic [4:0]  low;
  logic        any;

  // Lowest set index of the mask being walked: dirty at start, pending afterwards.
  always_comb begin
    src = (state == IDLE) ? dirty : pending;
    low = 5'd0;
    any = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (src[i]) begin
        low = 5'(i);
        any = 1'b1;
      end
    end
    src_rest = src & ~(32'd1 << low);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty   <= '0;
      pending <= '0;
    end else begin
      if (start) dirty <= '0;
      if (wr)    dirty[bus.wb_a] <= 1'b1;
      if (load)  pending <= src_rest;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_idx  = 5'd0;
    load_last = 1'b0;
    unique case (state)
      IDLE: if (start) begin
`ifdef WB_SHADOW_DIRTY_ONLY_EN
        if (any) begin
          state_n   = SEND;
          load      = 1'b1;
          load_idx  = low;
          load_last = (src_rest == '0);
        end else begin
          state_n = DONE;
        end
`else
        state_n = SEND;
        load    = 1'b1;
`endif
      end
      SEND: if (hs) begin
        if (last_q) begin
          state_n = DONE;
        end else begin
          load = 1'b1;
`ifdef WB_SHADOW_DIRTY_ONLY_EN
          load_idx  = low;
          load_last = (src_rest == '0);
`else
          load_idx  = idx_q + 5'd1;
          load_last = (idx_q == 5'd30);
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Entry 0 is never written, so it reads back as 0 without a special case.
  always_comb begin
    load_data = shadow[load_idx];
    if (wr && (bus.wb_a == load_idx)) load_data = bus.wb_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
      commit_cnt_q <= '0;
      dump_q       <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      dump_q <= bus.dump;
      if (bus.wb_e) commit_cnt_q <= commit_cnt_q + 32'd1;
      if (wr)       shadow[bus.wb_a] <= bus.wb_d;
      // Beat fields only move on a load, which keeps them stable under backpressure.
      if (load) begin
        idx_q  <= load_idx;
        data_q <= load_data;
        last_q <= load_last;
      end
    end
  end

  assign bus.out_valid  = (state == SEND);
  assign bus.busy       = (state == SEND);
  assign bus.dump_done  = (state == DONE);
  assign bus.out_idx    = idx_q;
  assign bus.out_data   = data_q;
  assign bus.out_last   = last_q;
  assign bus.commit_cnt = commit_cnt_q;
endmodule
